pixel_sweep_gen: RTL

PIXEL_SWEEP_GEN -- requirements
Module: pixel_sweep_gen

---
 rtl/pixel_sweep_gen_if.sv | 22 ++
 rtl/pixel_sweep_gen.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pixel_sweep_gen_if.sv
// Pixel write port between pixel_sweep_gen and a downstream neopixel writer.
// The writer captures color/address on the rising edge of color_clock.
interface pixel_sweep_gen_if;
  logic [23:0] color;
  logic [15:0] address;
  logic        color_clock;
  logic        frame_done;

  modport master (
    output color,
    output address,
    output color_clock,
    output frame_done
  );

  modport slave (
    input color,
    input address,
    input color_clock,
    input frame_done
  );
endinterface

// File: rtl/pixel_sweep_gen.sv
// Sweeps a fixed colour palette across NUM_LEDS pixels, one write per tick.
// Optional brightness scaling is compiled in with PIXEL_SWEEP_BRIGHTNESS_EN.
module pixel_sweep_gen #(
  parameter int unsigned NUM_LEDS = 64,
  parameter int unsigned TICK_DIV = 131072
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [7:0]         brightness,
  output logic               led,
  pixel_sweep_gen_if.master  wr
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
  localparam logic [15:0] LAST_ADDR = 16'(NUM_LEDS - 1);
  localparam logic [2:0]  LAST_PAL  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_RELEASE,
    S_ADVANCE
  } state_t;

  state_t            state;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              strobe_second;
  logic [2:0]        pal_idx;
  logic [23:0]       next_color;

  function automatic logic [23:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFF0000;
      3'd1:    return 24'h00FF00;
      3'd2:    return 24'h0000FF;
      3'd3:    return 24'hFFFF00;
      3'd4:    return 24'h00FFFF;
      3'd5:    return 24'hFF00FF;
      3'd6:    return 24'h010101;
      default: return 24'hFF0000;
    endcase
  endfunction

`ifdef PIXEL_SWEEP_BRIGHTNESS_EN
  // (ch * (b+1)) >> 8; the product peaks at 255*256 so 16 bits suffice
  function automatic logic [7:0] scale(input logic [7:0] ch, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'(ch) * (16'(b) + 16'd1);
    return prod[15:8];
  endfunction

  always_comb begin
    next_color = palette(pal_idx);
    next_color = {scale(next_color[23:16], brightness),
                  scale(next_color[15:8],  brightness),
                  scale(next_color[7:0],   brightness)};
  end
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign next_color        = palette(pal_idx);
`endif

  assign tick = enable && (tick_cnt == TICK_MAX);

  // Tick divider and heartbeat; the count freezes while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      led      <= 1'b0;
    end else if (enable) begin
      if (tick) begin
        tick_cnt <= '0;
        led      <= ~led;
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
    end
  end

  // Write sequencer; a tick seen outside IDLE is simply dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      strobe_second  <= 1'b0;
      pal_idx        <= '0;
      wr.address     <= '0;
      wr.color       <= 24'hFF0000;
      wr.color_clock <= 1'b0;
      wr.frame_done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tick) begin
            state    <= S_SETUP;
            wr.color <= next_color;
          end
        end
        S_SETUP: begin
          state          <= S_STROBE;
          strobe_second  <= 1'b0;
          wr.color_clock <= 1'b1;
        end
        S_STROBE: begin
          if (!strobe_second) begin
            strobe_second <= 1'b1;
          end else begin
            state          <= S_RELEASE;
            wr.color_clock <= 1'b0;
          end
        end
        S_RELEASE: begin
          state <= S_ADVANCE;
          if (wr.address == LAST_ADDR) begin
            wr.address    <= '0;
            wr.frame_done <= 1'b1;
            pal_idx       <= (pal_idx == LAST_PAL) ? 3'd0 : pal_idx + 3'd1;
          end else begin
            wr.address <= wr.address + 16'd1;
          end
        end
        S_ADVANCE: begin
          state         <= S_IDLE;
          wr.frame_done <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
